// File: rtl/vts_pkg.sv
// Shared state encoding and width helpers for the vector test sequencer.
package vts_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } vts_state_t;

    function automatic int vts_vec_w(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

    // Enough bits to count every vector of a run failing.
    function automatic int vts_cnt_w(input int num_vec);
        return $clog2(num_vec + 1);
    endfunction

endpackage

// File: rtl/vts_vector_rom.sv
// Test vector store with a registered read port; contents are loaded through the write port.
module vts_vector_rom #(
    parameter int ADDR_W = 5,
    parameter int VEC_W  = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [VEC_W-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [VEC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vector_test_sequencer.sv
// Self-test sequencer: walks stored vectors, drives the DUT, compares and counts mismatches.
// Optional build macro VTS_STOP_ON_FAIL_EN ends a run at the first failing vector.
module vector_test_sequencer
    import vts_pkg::*;
#(
    parameter int IN_W       = 2,
    parameter int OUT_W      = 1,
    parameter int NUM_VEC    = 24,
    parameter int ADDR_W     = 5,
    parameter int SETTLE_CYC = 1,
    localparam int VEC_W     = vts_vec_w(IN_W, OUT_W),
    localparam int CNT_W     = vts_cnt_w(NUM_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [VEC_W-1:0]  vec_data,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_fail
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VEC - 1);

    vts_state_t        state;
    vts_state_t        state_next;
    logic [ADDR_W-1:0] idx;
    logic [OUT_W-1:0]  exp_val;
    logic [SET_W-1:0]  settle_cnt;
    logic              check_fail;

    assign check_fail = (dut_out != exp_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_CHECK;
            ST_CHECK: begin
`ifdef VTS_STOP_ON_FAIL_EN
                if (check_fail || idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FETCH;
                end
`else
                if (idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FETCH;
                end
`endif
            end
            ST_DONE:   if (start) state_next = ST_FETCH;
            default:   state_next = ST_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            exp_val    <= '0;
            dut_in     <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            mismatch   <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (!abort) begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            idx        <= '0;
                            err_count  <= '0;
                            first_fail <= '0;
                        end
                    end
                    ST_LOAD: begin
                        dut_in     <= vec_data[VEC_W-1:OUT_W];
                        exp_val    <= vec_data[OUT_W-1:0];
                        settle_cnt <= '0;
                    end
                    ST_SETTLE: begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                    ST_CHECK: begin
                        if (check_fail) begin
                            err_count <= err_count + CNT_W'(1);
                            mismatch  <= 1'b1;
                            if (err_count == '0) begin
                                first_fail <= idx;
                            end
                        end
                        if (state_next == ST_FETCH) begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign vec_addr = idx;
    assign busy     = (state == ST_FETCH) || (state == ST_LOAD) ||
                      (state == ST_SETTLE) || (state == ST_CHECK);
    assign done     = (state == ST_DONE);
    assign pass     = done && (err_count == '0);

endmodule

// File: tb/tb_vector_test_sequencer.sv
// Bench for vector_test_sequencer with an XOR gate as DUT; two instances cover a short
// run (4 vectors, settle 1) and a long run (24 vectors, settle 3).
module tb_vector_test_sequencer;

`ifdef VTS_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic clk;
    logic reset;
    logic start;
    logic abort;
    logic sel;
    logic wrEn;
    logic [4:0] wrAddr;
    logic [2:0] wrData;

    logic [4:0] vecAddrA, vecAddrB, firstFailA, firstFailB;
    logic [2:0] vecDataA, vecDataB;
    logic [1:0] dutInA, dutInB;
    logic       dutOutA, dutOutB;
    logic       busyA, busyB, doneA, doneB, passA, passB, mismatchA, mismatchB;
    logic [2:0] errCountA;
    logic [4:0] errCountB;

    logic [7:0] obsErr;
    logic [4:0] obsFf, obsAddr;
    logic [1:0] obsDutIn;
    logic       obsBusy, obsDone, obsPass, obsMismatch;

    logic [2:0] romImage [0:23];
    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dutOutA = ^dutInA;
    assign dutOutB = ^dutInB;

    assign obsErr      = sel ? {3'b000, errCountB} : {5'b00000, errCountA};
    assign obsFf       = sel ? firstFailB : firstFailA;
    assign obsAddr     = sel ? vecAddrB : vecAddrA;
    assign obsDutIn    = sel ? dutInB : dutInA;
    assign obsBusy     = sel ? busyB : busyA;
    assign obsDone     = sel ? doneB : doneA;
    assign obsPass     = sel ? passB : passA;
    assign obsMismatch = sel ? mismatchB : mismatchA;

    vts_vector_rom #(.ADDR_W(5), .VEC_W(3)) romA (
        .clk(clk), .wr_en(wrEn && !sel), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(vecAddrA), .rd_data(vecDataA)
    );

    vts_vector_rom #(.ADDR_W(5), .VEC_W(3)) romB (
        .clk(clk), .wr_en(wrEn && sel), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(vecAddrB), .rd_data(vecDataB)
    );

    vector_test_sequencer #(
        .IN_W(2), .OUT_W(1), .NUM_VEC(4), .ADDR_W(5), .SETTLE_CYC(1)
    ) dutA (
        .clk(clk), .reset(reset), .start(start && !sel), .abort(abort && !sel),
        .vec_addr(vecAddrA), .vec_data(vecDataA), .dut_in(dutInA), .dut_out(dutOutA),
        .busy(busyA), .done(doneA), .pass(passA), .mismatch(mismatchA),
        .err_count(errCountA), .first_fail(firstFailA)
    );

    vector_test_sequencer #(
        .IN_W(2), .OUT_W(1), .NUM_VEC(24), .ADDR_W(5), .SETTLE_CYC(3)
    ) dutB (
        .clk(clk), .reset(reset), .start(start && sel), .abort(abort && sel),
        .vec_addr(vecAddrB), .vec_data(vecDataB), .dut_in(dutInB), .dut_out(dutOutB),
        .busy(busyB), .done(doneB), .pass(passB), .mismatch(mismatchB),
        .err_count(errCountB), .first_fail(firstFailB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 32'(obsBusy), 0);
        checkOutput({tag, "_done"}, 32'(obsDone), 0);
        checkOutput({tag, "_pass"}, 32'(obsPass), 0);
        checkOutput({tag, "_mismatch"}, 32'(obsMismatch), 0);
        checkOutput({tag, "_err"}, 32'(obsErr), 0);
        checkOutput({tag, "_ff"}, 32'(obsFf), 0);
        checkOutput({tag, "_addr"}, 32'(obsAddr), 0);
        checkOutput({tag, "_dutin"}, 32'(obsDutIn), 0);
    endtask

    task automatic loadRom(input int n);
        for (int i = 0; i < n; i++) begin
            wrEn   = 1'b1;
            wrAddr = 5'(i);
            wrData = romImage[i];
            @(negedge clk);
        end
        wrEn = 1'b0;
    endtask

    // Vector i passes when XOR of its two input bits equals its expected bit.
    task automatic modelRun(input int n, output int eErr, output int eFf,
                            output int eProc, output int eLast);
        eErr  = 0;
        eFf   = 0;
        eProc = n;
        eLast = n - 1;
        for (int i = 0; i < n; i++) begin
            logic [2:0] v;
            v = romImage[i];
            if ((v[2] ^ v[1]) != v[0]) begin
                if (eErr == 0) eFf = i;
                eErr++;
                if (STOP_ON_FAIL) begin
                    eProc = i + 1;
                    eLast = i;
                    break;
                end
            end
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One complete run on the selected instance; extraAt > 0 also pulses start mid-run.
    task automatic applyStimulus(input string tag, input int n, input int extraAt);
        int p, eErr, eFf, eProc, eLast, cnt, mm, addrBad, expAddr, budget;
        logic [2:0] lastVec;
        p = sel ? 6 : 4;
        modelRun(n, eErr, eFf, eProc, eLast);
        lastVec = romImage[eLast];
        budget = p * n + 20;
        cnt = 0;
        mm = 0;
        addrBad = 0;
        pulseStart();
        while (!obsDone && cnt < budget) begin
            if (extraAt != 0 && cnt == extraAt) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cnt++;
            if (obsMismatch) mm++;
            expAddr = cnt / p;
            if (expAddr > eLast) expAddr = eLast;
            if (32'(obsAddr) != expAddr) addrBad++;
        end
        checkOutput({tag, "_done_seen"}, 32'(obsDone), 1);
        checkOutput({tag, "_done_cycle"}, cnt, p * eProc);
        checkOutput({tag, "_err_count"}, 32'(obsErr), eErr);
        checkOutput({tag, "_first_fail"}, 32'(obsFf), eFf);
        checkOutput({tag, "_pass"}, 32'(obsPass), (eErr == 0) ? 1 : 0);
        checkOutput({tag, "_mismatch_pulses"}, mm, eErr);
        checkOutput({tag, "_addr_seq_bad"}, addrBad, 0);
        checkOutput({tag, "_final_addr"}, 32'(obsAddr), eLast);
        checkOutput({tag, "_final_dutin"}, 32'(obsDutIn), 32'(lastVec[2:1]));
        checkOutput({tag, "_busy"}, 32'(obsBusy), 0);
    endtask

    task automatic randomRom(input int n, input int flipOneIn);
        for (int i = 0; i < n; i++) begin
            logic [1:0] inV;
            logic flip;
            inV  = 2'($urandom_range(0, 3));
            flip = (flipOneIn > 0) && ($urandom_range(0, flipOneIn - 1) == 0);
            romImage[i] = {inV, (inV[1] ^ inV[0]) ^ flip};
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        sel    = 1'b0;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        repeat (3) @(negedge clk);
        checkResetState("resetA");
        sel = 1'b1;
        #1;
        checkResetState("resetB");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] clean XOR table");
        romImage[0] = 3'b000;
        romImage[1] = 3'b011;
        romImage[2] = 3'b101;
        romImage[3] = 3'b110;
        loadRom(4);
        applyStimulus("clean", 4, 0);

        $display("[TB] entry 2 corrupted");
        romImage[2] = 3'b100;
        loadRom(4);
        applyStimulus("corrupt", 4, 0);

        $display("[TB] start while busy, then restart from done");
        applyStimulus("busy_start", 4, 3);
        applyStimulus("restart", 4, 0);

        $display("[TB] random short runs");
        for (int r = 0; r < 6; r++) begin
            randomRom(4, 3);
            loadRom(4);
            applyStimulus($sformatf("randA%0d", r), 4, 0);
        end

        $display("[TB] reset mid-run");
        pulseStart();
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus("after_reset", 4, 0);

        $display("[TB] abort mid-run");
        romImage[0] = 3'b001;
        romImage[1] = 3'b011;
        romImage[2] = 3'b101;
        romImage[3] = 3'b110;
        loadRom(4);
        pulseStart();
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 32'(obsBusy), 0);
        checkOutput("abort_done", 32'(obsDone), 0);
        checkOutput("abort_err_kept", 32'(obsErr), 1);
        checkOutput("abort_ff_kept", 32'(obsFf), 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("start_abort_busy", 32'(obsBusy), 0);
        checkOutput("start_abort_done", 32'(obsDone), 0);
        checkOutput("start_abort_err_kept", 32'(obsErr), 1);
        applyStimulus("after_abort", 4, 0);

        $display("[TB] long runs, 24 vectors, settle 3");
        sel = 1'b1;
        @(negedge clk);
        randomRom(24, 0);
        loadRom(24);
        applyStimulus("longClean", 24, 0);
        for (int r = 0; r < 3; r++) begin
            randomRom(24, 5);
            loadRom(24);
            applyStimulus($sformatf("longRand%0d", r), 24, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
